// File: rtl/screen_mode_ctrl_if.sv
// ---------------------------------------------------------------------------
// screen_mode_ctrl_if
//   Signal bundle between the screen sequencer and the rest of the VGA front
//   end (timing block, button pad, game logic, start-screen renderer).
//
//   frame_tick     1  one-clk pulse per video frame (from VGA timing)
//   btn_start      1  raw start button, asynchronous, active-high
//   game_over      1  level from game logic
//   mode           2  0=TITLE 1=FADE_OUT 2=PLAY 3=GAMEOVER
//   title_visible  1  renderer shows title text
//   prompt_visible 1  renderer shows blinking prompt
//   brightness     3  7=full, 0=black
//   game_run       1  game logic enable
//   demo           1  attract/demo play active
//
//   master: the sequencer (screen_mode_ctrl)
//   slave : everything around it
// ---------------------------------------------------------------------------
interface screen_mode_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic       game_over;
    logic [1:0] mode;
    logic       title_visible;
    logic       prompt_visible;
    logic [2:0] brightness;
    logic       game_run;
    logic       demo;

    modport master (
        input  frame_tick, btn_start, game_over,
        output mode, title_visible, prompt_visible, brightness, game_run, demo
    );

    modport slave (
        output frame_tick, btn_start, game_over,
        input  mode, title_visible, prompt_visible, brightness, game_run, demo
    );
endinterface

// File: rtl/screen_mode_ctrl.sv
// ---------------------------------------------------------------------------
// screen_mode_ctrl
//   Top-level screen sequencer: TITLE -> FADE_OUT -> PLAY -> GAMEOVER -> TITLE.
//   Debounces the start button, paces everything off frame_tick and drives
//   the start-screen renderer controls and the game enable. All outputs are
//   registered.
//
//   Ports:
//     clk   1  system clock
//     rst   1  asynchronous, active-high reset
//     bus      screen_mode_ctrl_if.master (frame_tick, btn_start, game_over in;
//              mode, title_visible, prompt_visible, brightness, game_run,
//              demo out)
//
//   Optional feature macro: SCREEN_ATTRACT_EN
//     defined   : idle TITLE frames start a demo PLAY after ATTRACT_FRAMES;
//                 start or game_over during demo returns to TITLE.
//     undefined : no idle counter, demo tied low.
// ---------------------------------------------------------------------------
module screen_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned FADE_STEP       = 4,
    parameter int unsigned GAMEOVER_FRAMES = 180
`ifdef SCREEN_ATTRACT_EN
   ,parameter int unsigned ATTRACT_FRAMES  = 600
`endif
) (
    input  logic                clk,
    input  logic                rst,
    screen_mode_ctrl_if.master  bus
);

    localparam logic [1:0] ST_TITLE    = 2'd0;
    localparam logic [1:0] ST_FADE     = 2'd1;
    localparam logic [1:0] ST_PLAY     = 2'd2;
    localparam logic [1:0] ST_GAMEOVER = 2'd3;

    localparam int unsigned FMAX_A = (BLINK_FRAMES > FADE_STEP) ? BLINK_FRAMES : FADE_STEP;
    localparam int unsigned FMAX   = (FMAX_A > GAMEOVER_FRAMES) ? FMAX_A : GAMEOVER_FRAMES;
    localparam int          FCW    = $clog2(FMAX + 1);
    localparam int          DBW    = $clog2(DEBOUNCE_CYCLES + 1);

    // ---------------- button synchroniser + debouncer ----------------
    logic           sync1, sync2;
    logic           db_level;
    logic [DBW-1:0] db_cnt;
    logic           start_evt;

    // db_cnt counts consecutive synced samples that disagree with the
    // debounced level; an agreeing sample clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            db_level  <= 1'b0;
            db_cnt    <= '0;
            start_evt <= 1'b0;
        end else begin
            sync1     <= bus.btn_start;
            sync2     <= sync1;
            start_evt <= 1'b0;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                db_level  <= sync2;
                db_cnt    <= '0;
                start_evt <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // ---------------- attract / demo ----------------
    logic state_title_sel;
    logic [1:0] state_r;
    logic attract_hit;
    logic in_demo;

    assign state_title_sel = (state_r == ST_TITLE);

`ifdef SCREEN_ATTRACT_EN
    localparam int IW = $clog2(ATTRACT_FRAMES + 1);
    logic [IW-1:0] idle_cnt;
    logic          demo_r;

    assign attract_hit = bus.frame_tick && (idle_cnt == IW'(ATTRACT_FRAMES - 1));
    assign in_demo     = demo_r;
    assign bus.demo    = demo_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (!state_title_sel || start_evt) begin
            idle_cnt <= '0;
        end else if (bus.frame_tick) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Tracks the FSM's demo entry/exit on the same edge as the state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            demo_r <= 1'b0;
        end else if (state_title_sel && !start_evt && attract_hit) begin
            demo_r <= 1'b1;
        end else if (state_r == ST_PLAY && (start_evt || bus.game_over)) begin
            demo_r <= 1'b0;
        end else if (state_r != ST_PLAY) begin
            demo_r <= 1'b0;
        end
    end
`else
    assign attract_hit = 1'b0;
    assign in_demo     = 1'b0;
    assign bus.demo    = 1'b0;
`endif

    // ---------------- screen FSM ----------------
    logic [FCW-1:0] frame_cnt;
    logic           title_r, prompt_r, run_r;
    logic [2:0]     bright_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_TITLE;
            frame_cnt <= '0;
            title_r   <= 1'b1;
            prompt_r  <= 1'b1;
            bright_r  <= 3'd7;
            run_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_TITLE: begin
                    if (start_evt) begin
                        // start wins over a coincident frame_tick
                        state_r   <= ST_FADE;
                        frame_cnt <= '0;
                        title_r   <= 1'b1;
                        prompt_r  <= 1'b0;
                        bright_r  <= 3'd7;
                    end else if (attract_hit) begin
                        state_r   <= ST_PLAY;
                        frame_cnt <= '0;
                        title_r   <= 1'b0;
                        prompt_r  <= 1'b0;
                        bright_r  <= 3'd7;
                        run_r     <= 1'b1;
                    end else if (frame_cnt == FCW'(BLINK_FRAMES)) begin
                        // toggle on the edge after the count is reached; a
                        // tick arriving on that edge starts the next period
                        prompt_r  <= ~prompt_r;
                        frame_cnt <= bus.frame_tick ? FCW'(1) : '0;
                    end else if (bus.frame_tick) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end

                ST_FADE: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt == FCW'(FADE_STEP - 1)) begin
                            frame_cnt <= '0;
                            if (bright_r == 3'd0) begin
                                state_r  <= ST_PLAY;
                                title_r  <= 1'b0;
                                prompt_r <= 1'b0;
                                bright_r <= 3'd7;
                                run_r    <= 1'b1;
                            end else begin
                                bright_r <= bright_r - 3'd1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (in_demo && (start_evt || bus.game_over)) begin
                        state_r   <= ST_TITLE;
                        frame_cnt <= '0;
                        title_r   <= 1'b1;
                        prompt_r  <= 1'b1;
                        bright_r  <= 3'd7;
                        run_r     <= 1'b0;
                    end else if (!in_demo && bus.game_over) begin
                        state_r   <= ST_GAMEOVER;
                        frame_cnt <= '0;
                        title_r   <= 1'b0;
                        prompt_r  <= 1'b0;
                        run_r     <= 1'b0;
                    end
                end

                ST_GAMEOVER: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt == FCW'(GAMEOVER_FRAMES - 1)) begin
                            state_r   <= ST_TITLE;
                            frame_cnt <= '0;
                            title_r   <= 1'b1;
                            prompt_r  <= 1'b1;
                            bright_r  <= 3'd7;
                            run_r     <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state_r   <= ST_TITLE;
                    frame_cnt <= '0;
                    title_r   <= 1'b1;
                    prompt_r  <= 1'b1;
                    bright_r  <= 3'd7;
                    run_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mode           = state_r;
    assign bus.title_visible  = title_r;
    assign bus.prompt_visible = prompt_r;
    assign bus.brightness     = bright_r;
    assign bus.game_run       = run_r;

endmodule

// File: tb/tb_screen_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_screen_mode_ctrl
//   Directed scenarios followed by a randomized phase, all checked against a
//   frame/event-level reference model of the screen flow.
// ---------------------------------------------------------------------------
module tb_screen_mode_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned FS = 1;
    localparam int unsigned GF = 3;
`ifdef SCREEN_ATTRACT_EN
    localparam int unsigned AF = 5;
    localparam bit ATTRACT = 1'b1;
`else
    localparam int unsigned AF = 0;
    localparam bit ATTRACT = 1'b0;
`endif

    localparam int S_TITLE = 0;
    localparam int S_FADE  = 1;
    localparam int S_PLAY  = 2;
    localparam int S_GO    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    screen_mode_ctrl_if bus();

    screen_mode_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .BLINK_FRAMES    (BF),
        .FADE_STEP       (FS),
        .GAMEOVER_FRAMES (GF)
`ifdef SCREEN_ATTRACT_EN
       ,.ATTRACT_FRAMES  (AF)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: current screen, frames seen in it, idle frames, demo
    int m_state = S_TITLE;
    int m_n     = 0;
    int m_idle  = 0;
    bit m_demo  = 1'b0;
    int lat     = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_bright();
        return (m_state == S_FADE) ? 7 - m_n / int'(FS) : 7;
    endfunction

    // Prompt as seen right after the n-th TITLE frame tick: one toggle per
    // BLINK_FRAMES frames, landing the frame after the count is reached.
    function automatic int exp_prompt();
        if (m_state != S_TITLE) return 0;
        if (m_n == 0) return 1;
        return 1 ^ (((m_n - 1) / int'(BF)) % 2);
    endfunction

    task automatic check_all(input string tag, input bit chk_prompt);
        check_val({tag, ".mode"},   bus.mode, m_state);
        check_val({tag, ".title"},  bus.title_visible, (m_state == S_TITLE || m_state == S_FADE) ? 1 : 0);
        check_val({tag, ".run"},    bus.game_run, (m_state == S_PLAY) ? 1 : 0);
        check_val({tag, ".bright"}, bus.brightness, exp_bright());
        check_val({tag, ".demo"},   bus.demo, m_demo ? 1 : 0);
        if (m_state == S_FADE || m_state == S_PLAY || (m_state == S_TITLE && chk_prompt))
            check_val({tag, ".prompt"}, bus.prompt_visible, exp_prompt());
    endtask

    task automatic enter(input int s);
        m_state = s;
        m_n     = 0;
        m_idle  = 0;
        if (s != S_PLAY) m_demo = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_start();
        if (m_state == S_TITLE) enter(S_FADE);
        else if (m_state == S_PLAY && m_demo) enter(S_TITLE);
    endtask

    task automatic do_tick(input string tag);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        case (m_state)
            S_TITLE: begin
                if (ATTRACT && m_idle + 1 == int'(AF)) begin
                    enter(S_PLAY);
                    m_demo = 1'b1;
                end else begin
                    m_n++;
                    m_idle++;
                end
            end
            S_FADE: begin
                m_n++;
                if (m_n == 8 * int'(FS)) enter(S_PLAY);
            end
            S_GO: begin
                m_n++;
                if (m_n == int'(GF)) enter(S_TITLE);
            end
            default: ;
        endcase
        check_all(tag, 1'b1);
    endtask

    task automatic press(input string tag, input int len);
        bus.btn_start = 1'b1;
        repeat (len) step();
        bus.btn_start = 1'b0;
        repeat (DB + 6) step();
        if (len >= int'(DB)) apply_start();
        check_all(tag, 1'b0);
    endtask

    task automatic gover(input string tag);
        bus.game_over = 1'b1;
        repeat (2) step();
        bus.game_over = 1'b0;
        step();
        if (m_state == S_PLAY) begin
            if (m_demo) enter(S_TITLE);
            else        enter(S_GO);
        end
        check_all(tag, 1'b0);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.btn_start  = 1'b0;
        bus.game_over  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        enter(S_TITLE);
        check_all("reset", 1'b1);
        rst = 1'b0;
        step();

        // glitch shorter than the debounce window
        press("short3", 3);

        // long press: also measures button-to-mode latency for the collision case
        bus.btn_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (lat == 0 && bus.mode == 2'd1) lat = i;
        end
        bus.btn_start = 1'b0;
        repeat (DB + 6) step();
        check_val("start_seen", (lat != 0) ? 1 : 0, 1);
        if (lat == 0) lat = int'(DB) + 3;
        apply_start();
        check_all("long10", 1'b0);

        // fade: brightness 6..0 then PLAY on the 8th tick
        for (int i = 0; i < 8; i++) do_tick("fade");

        gover("gover");
        press("press_in_go", int'(DB) + 4);
        for (int i = 0; i < int'(GF); i++) do_tick("go_tick");

        // blink sequence 1,1,0,0,1,1
        for (int i = 0; i < 6; i++) do_tick("blink");

`ifdef SCREEN_ATTRACT_EN
        press("demo_exit", int'(DB) + 4);
`else
        for (int i = 0; i < 20; i++) do_tick("idle");
`endif

        // start_evt and frame_tick on the same cycle in TITLE
        check_val("col_pre_title", bus.mode, S_TITLE);
        bus.btn_start = 1'b1;
        repeat (lat - 1) step();
        check_val("col_pre_edge", bus.mode, S_TITLE);
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        apply_start();
        check_all("collision", 1'b0);
        repeat (10 - lat) step();
        bus.btn_start = 1'b0;
        repeat (DB + 6) step();
        check_all("col_settle", 1'b0);
        press("press_in_fade", int'(DB) + 4);
        for (int i = 0; i < 8; i++) do_tick("col_fade");

        // reset asynchronously in the middle of PLAY
        for (int i = 0; i < 40 && m_state != S_PLAY; i++) begin
            if (m_state == S_TITLE) press("to_play", int'(DB) + 4);
            else                    do_tick("to_play");
        end
        check_val("pre_reset_play", bus.mode, S_PLAY);
        #2;
        rst = 1'b1;
        #1;
        enter(S_TITLE);
        check_all("reset_mid", 1'b1);
        step();
        rst = 1'b0;
        step();

        // randomized phase
        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60) begin
                repeat ($urandom_range(0, 2)) step();
                do_tick("rnd_tick");
            end else if (r < 72) begin
                press("rnd_short", $urandom_range(1, DB - 1));
            end else if (r < 85) begin
                press("rnd_long", $urandom_range(DB + 1, DB + 6));
            end else begin
                gover("rnd_gover");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time bound so a stuck run still ends
    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
